seq_control_unit: RTL and testbench
===================================

Name: seq_control_unit

Overview:
- Parametrised multi-cycle control unit for the 8-bit CPU. Successor to the fixed 2-bit-timer control unit.
- Generalises bus-ID width and T-state depth.
- Adds variable-length instructions: absolute and conditional jumps through AR.
- Adds an explicit HALT state with a resume handshake.
- Drives the data-bus MID/SID decoders, the address-bus AMID decoder, PC/AR increment and ALU enable, from IR0 and ALU status.

Parameters:
- ID_WIDTH, 3: width of MID/SID fields; idle code is all-ones.
- TCNT_WIDTH, 3: T-state counter width; at least 3 required for JMP (T0..T4).
- ALU_OP_WIDTH, 5: ALU opcode width.
- ZF_BIT, 0: alu_status bit used as the zero flag.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- hlt  in  1  external freeze; sequencer holds state, all enables low
- resume  in  1  single-cycle pulse; leaves HALT
- ir0  in  8  instruction register contents
- alu_status  in  4  ALU flags
- mid / sid  out  ID_WIDTH  data-bus master / slave ID
- mid_en / sid_en  out  1  decoder enables
- amid  out  2  address master: 0 PC, 1 AR, 2 SP, 3 R0R1
- pc_inr / ar_inr  out  1  PC / AR increment
- alu_en  out  1  ALU load into accumulator
- alu_opcode  out  ALU_OP_WIDTH  equals ir0[ALU_OP_WIDTH-1:0] when alu_en is high, else 0
- t_state  out  TCNT_WIDTH  current T-state
- halted  out  1  high while in HALT

Behaviour:
- Data-bus ID encoding: IR0=0, MEM=1, A=2, B=3, AR0=4, AR1=5, PC0=6, PC1=7.
- Opcode format:
  - [7:6] type: 0 MOV, 1 MVI, 2 ALU, 3 SYS.
  - MOV/MVI: [5:3] MID, [2:0] SID.
  - SYS sub-op in [5:0]: 0 NOP, 1 HLT, 2 INC_AR, 3 JMP, 4 JZ; all other values execute as NOP.
- FSM states: RUN, HALT. In RUN, t_state counts from 0 and clears to 0 after the last T-state of each instruction.
- Reset: state=RUN, t_state=0, halted=0, all outputs idle (IDs all-ones, enables 0, amid=0). The first fetch occurs in the cycle after reset deasserts. Reset mid-instruction aborts immediately.
- T0, every instruction (fetch): mid=MEM, sid=IR0, en=1, amid=PC, pc_inr=1.
- MOV, T1: mid=ir0[5:3], sid=ir0[2:0], en=1. amid=AR if either ID is MEM, else PC. Ends.
- MVI, T1: mid=MEM, sid=ir0[2:0], en=1, amid=PC, pc_inr=1. Ends.
- ALU, T1: alu_en=1, alu_opcode=ir0[4:0], en=0. Ends.
- NOP, T1: idle outputs. Ends.
- INC_AR, T1: ar_inr=1. Ends.
- HLT, T1: enter HALT; t_state holds 1, halted=1, outputs idle.
  - A resume pulse while halted returns to RUN with t_state=0.
  - A resume pulse outside HALT is ignored.
- JMP:
  - T1: MEM→AR0, amid=PC, pc_inr=1.
  - T2: MEM→AR1, amid=PC, pc_inr=1.
  - T3: AR0→PC0.
  - T4: AR1→PC1. Ends.
- JZ: T1 and T2 as JMP.
  - At T2, sample alu_status[ZF_BIT].
  - If 1: T3 and T4 as JMP.
  - If 0: end after T2; PC already points past the operands.
- hlt high: t_state and state frozen; every output enable (mid_en, sid_en, pc_inr, ar_inr, alu_en) forced to 0. Execution resumes at the same T-state when hlt falls. hlt takes priority over resume.
- All outputs are combinational from state, t_state and ir0. ir0 must be stable from T1 onward, since it is written at the end of T0.

Optional Feature:
- Macro: CU_RETIRE_CNT_EN.
- With the macro defined: adds output retired (32 bits), reset to 0, incremented by 1 in the final T-state of each completed instruction (including HLT at entry to HALT). It wraps at 2^32 and does not count while hlt is high.
- Without the macro: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package seq_cu_pkg holds:
  - bus-ID localparams (ID_IR0..ID_PC1, ID_IDLE);
  - type codes;
  - SYS sub-op codes;
  - AMID codes;
  - FSM state enum.
- Sub-module tstate_counter: TCNT_WIDTH-bit counter with sync clear, hold enable and sync reset.

Test Plan:
- Reset then MOV A→B (0x13) → T0: mid=1, sid=0, pc_inr=1, amid=0; T1: mid=2, sid=3, en=1, amid=0; next cycle t_state=0.
- MOV MEM→A (0x0A) → T1 amid=1. MVI A (0x42) → T1 mid=1, sid=2, pc_inr=1, amid=0.
- JMP (0xC3) → pc_inr high in T0, T1, T2; T3 mid=4, sid=6; T4 mid=5, sid=7; t_state returns to 0 after 5 cycles.
- JZ (0xC4) with alu_status=0 → ends after T2, no PC0/PC1 writes. With alu_status=4'b0001 → full 5-cycle sequence.
- HLT (0xC1) → halted=1 from the cycle after T1, outputs idle for 10 cycles; resume pulse → next cycle t_state=0 and fetch outputs.
- hlt held 3 cycles during JMP T2 → t_state stays 2 and all enables are 0; after hlt falls, T2 outputs re-issue and T3 follows. Reset asserted in T3 → t_state=0, outputs idle.

Source files
------------

// File: rtl/seq_control_unit_pkg.sv
// Shared encodings for the seq_control_unit sequencer: bus IDs, opcode fields,
// address-master codes and the FSM state type.
package seq_cu_pkg;

  localparam int ID_IR0 = 0;
  localparam int ID_MEM = 1;
  localparam int ID_A   = 2;
  localparam int ID_B   = 3;
  localparam int ID_AR0 = 4;
  localparam int ID_AR1 = 5;
  localparam int ID_PC0 = 6;
  localparam int ID_PC1 = 7;
  // Truncated to ID_WIDTH bits this becomes all-ones for any ID width.
  localparam int ID_IDLE = -1;

  localparam logic [1:0] TYPE_MOV = 2'd0;
  localparam logic [1:0] TYPE_MVI = 2'd1;
  localparam logic [1:0] TYPE_ALU = 2'd2;
  localparam logic [1:0] TYPE_SYS = 2'd3;

  localparam logic [5:0] SYS_NOP    = 6'd0;
  localparam logic [5:0] SYS_HLT    = 6'd1;
  localparam logic [5:0] SYS_INC_AR = 6'd2;
  localparam logic [5:0] SYS_JMP    = 6'd3;
  localparam logic [5:0] SYS_JZ     = 6'd4;

  localparam logic [1:0] AMID_PC   = 2'd0;
  localparam logic [1:0] AMID_AR   = 2'd1;
  localparam logic [1:0] AMID_SP   = 2'd2;
  localparam logic [1:0] AMID_R0R1 = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } cu_state_e;

endpackage

// File: rtl/seq_control_unit_tstate_counter.sv
// T-state counter: hold beats clear, clear beats increment, sync reset beats all.
module tstate_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hold_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (hold_i) begin
      count_d = count_q;
    end else if (clear_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit with variable-length jumps and a HALT state.
// Optional macro CU_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module seq_control_unit
  import seq_cu_pkg::*;
#(
  parameter int ID_WIDTH     = 3,
  parameter int TCNT_WIDTH   = 3,
  parameter int ALU_OP_WIDTH = 5,
  parameter int ZF_BIT       = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    hlt_i,
  input  logic                    resume_i,
  input  logic [7:0]              ir0_i,
  input  logic [3:0]              alu_status_i,
  output logic [ID_WIDTH-1:0]     mid_o,
  output logic [ID_WIDTH-1:0]     sid_o,
  output logic                    mid_en_o,
  output logic                    sid_en_o,
  output logic [1:0]              amid_o,
  output logic                    pc_inr_o,
  output logic                    ar_inr_o,
  output logic                    alu_en_o,
  output logic [ALU_OP_WIDTH-1:0] alu_opcode_o,
  output logic [TCNT_WIDTH-1:0]   t_state_o,
  output logic                    halted_o
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [31:0]             retired_o
`endif
);

  cu_state_e state_q, state_d;
  logic [TCNT_WIDTH-1:0] t_state;
  logic [ID_WIDTH-1:0] mid_c, sid_c;
  logic [1:0] amid_c;
  logic bus_en_c, pc_inr_c, ar_inr_c, alu_en_c, last_c, enter_halt_c;
  logic cnt_hold, cnt_clear;
  logic zf;
  logic unused_status;

  assign zf = alu_status_i[ZF_BIT];
  assign unused_status = ^alu_status_i;

  // Reset gates the decode so outputs go idle in the very cycle it is raised.
  always_comb begin
    mid_c        = ID_WIDTH'(ID_IDLE);
    sid_c        = ID_WIDTH'(ID_IDLE);
    bus_en_c     = 1'b0;
    amid_c       = AMID_PC;
    pc_inr_c     = 1'b0;
    ar_inr_c     = 1'b0;
    alu_en_c     = 1'b0;
    last_c       = 1'b0;
    enter_halt_c = 1'b0;
    if (!reset_i && state_q == ST_RUN) begin
      if (t_state == '0) begin
        mid_c    = ID_WIDTH'(ID_MEM);
        sid_c    = ID_WIDTH'(ID_IR0);
        bus_en_c = 1'b1;
        pc_inr_c = 1'b1;
      end else begin
        case (ir0_i[7:6])
          TYPE_MOV: begin
            mid_c    = ID_WIDTH'(ir0_i[5:3]);
            sid_c    = ID_WIDTH'(ir0_i[2:0]);
            bus_en_c = 1'b1;
            if (ir0_i[5:3] == 3'(ID_MEM) || ir0_i[2:0] == 3'(ID_MEM)) begin
              amid_c = AMID_AR;
            end
            last_c   = 1'b1;
          end
          TYPE_MVI: begin
            mid_c    = ID_WIDTH'(ID_MEM);
            sid_c    = ID_WIDTH'(ir0_i[2:0]);
            bus_en_c = 1'b1;
            pc_inr_c = 1'b1;
            last_c   = 1'b1;
          end
          TYPE_ALU: begin
            alu_en_c = 1'b1;
            last_c   = 1'b1;
          end
          default: begin
            case (ir0_i[5:0])
              SYS_HLT: begin
                if (t_state == TCNT_WIDTH'(1)) begin
                  enter_halt_c = 1'b1;
                end else begin
                  last_c = 1'b1;
                end
              end
              SYS_INC_AR: begin
                ar_inr_c = 1'b1;
                last_c   = 1'b1;
              end
              SYS_JMP, SYS_JZ: begin
                bus_en_c = 1'b1;
                if (t_state == TCNT_WIDTH'(1)) begin
                  mid_c    = ID_WIDTH'(ID_MEM);
                  sid_c    = ID_WIDTH'(ID_AR0);
                  pc_inr_c = 1'b1;
                end else if (t_state == TCNT_WIDTH'(2)) begin
                  mid_c    = ID_WIDTH'(ID_MEM);
                  sid_c    = ID_WIDTH'(ID_AR1);
                  pc_inr_c = 1'b1;
                  last_c   = (ir0_i[5:0] == SYS_JZ) && !zf;
                end else if (t_state == TCNT_WIDTH'(3)) begin
                  mid_c = ID_WIDTH'(ID_AR0);
                  sid_c = ID_WIDTH'(ID_PC0);
                end else begin
                  mid_c  = ID_WIDTH'(ID_AR1);
                  sid_c  = ID_WIDTH'(ID_PC1);
                  last_c = 1'b1;
                end
              end
              SYS_NOP: last_c = 1'b1;
              default: last_c = 1'b1;
            endcase
          end
        endcase
      end
    end
  end

  // hlt freezes both the FSM and the counter, and outranks resume.
  always_comb begin
    state_d = state_q;
    if (!hlt_i) begin
      if (state_q == ST_RUN && enter_halt_c) begin
        state_d = ST_HALT;
      end else if (state_q == ST_HALT && resume_i) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign cnt_hold  = hlt_i || enter_halt_c || (state_q == ST_HALT && !resume_i);
  assign cnt_clear = last_c || (state_q == ST_HALT && resume_i);

  tstate_counter #(
    .WIDTH(TCNT_WIDTH)
  ) u_tcnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .hold_i  (cnt_hold),
    .clear_i (cnt_clear),
    .count_o (t_state)
  );

  assign mid_o        = mid_c;
  assign sid_o        = sid_c;
  assign amid_o       = amid_c;
  assign mid_en_o     = bus_en_c && !hlt_i;
  assign sid_en_o     = bus_en_c && !hlt_i;
  assign pc_inr_o     = pc_inr_c && !hlt_i;
  assign ar_inr_o     = ar_inr_c && !hlt_i;
  assign alu_en_o     = alu_en_c && !hlt_i;
  assign alu_opcode_o = alu_en_o ? ir0_i[ALU_OP_WIDTH-1:0] : '0;
  assign t_state_o    = t_state;
  assign halted_o     = (state_q == ST_HALT);

`ifdef CU_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retired_q <= '0;
    end else if (!hlt_i && (last_c || enter_halt_c)) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_o = retired_q;
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// Table-driven bench for seq_control_unit: per-cycle vectors feed a scoreboard
// queue that is drained and compared half a clock later.
module tb_seq_control_unit;
  import seq_cu_pkg::*;

  localparam int IDLE = 7;

  logic       clk = 1'b0;
  logic       reset, hlt, resume;
  logic [7:0] ir0;
  logic [3:0] alu_status;
  logic [2:0] mid, sid, t_state;
  logic       mid_en, sid_en, pc_inr, ar_inr, alu_en, halted;
  logic [1:0] amid;
  logic [4:0] alu_opcode;
`ifdef CU_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  seq_control_unit dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .hlt_i        (hlt),
    .resume_i     (resume),
    .ir0_i        (ir0),
    .alu_status_i (alu_status),
    .mid_o        (mid),
    .sid_o        (sid),
    .mid_en_o     (mid_en),
    .sid_en_o     (sid_en),
    .amid_o       (amid),
    .pc_inr_o     (pc_inr),
    .ar_inr_o     (ar_inr),
    .alu_en_o     (alu_en),
    .alu_opcode_o (alu_opcode),
    .t_state_o    (t_state),
    .halted_o     (halted)
`ifdef CU_RETIRE_CNT_EN
    ,
    .retired_o    (retired)
`endif
  );

  typedef struct {
    string      tag;
    logic       rst;
    logic [7:0] ir;
    logic [3:0] st;
    logic       h;
    logic       r;
    logic [2:0] t;
    logic [2:0] mid;
    logic [2:0] sid;
    logic       en;
    logic [1:0] amid;
    logic       pc;
    logic       ar;
    logic       alu;
    logic       halted;
    logic       chkId;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;

  task automatic addVec(input string tag, input logic rst, input logic [7:0] ir,
                        input logic [3:0] st, input logic h, input logic r, input int t,
                        input int m, input int s, input logic en, input logic [1:0] am,
                        input logic pc, input logic ar, input logic alu,
                        input logic hd, input logic chkId);
    vec_t v;
    v.tag = tag; v.rst = rst; v.ir = ir; v.st = st; v.h = h; v.r = r;
    v.t = 3'(t); v.mid = 3'(m); v.sid = 3'(s); v.en = en; v.amid = am;
    v.pc = pc; v.ar = ar; v.alu = alu; v.halted = hd; v.chkId = chkId;
    vecs.push_back(v);
  endtask

  task automatic addFetch(input string tag, input logic [7:0] ir);
    addVec(tag, 1'b0, ir, 4'h0, 1'b0, 1'b0, 0, ID_MEM, ID_IR0, 1'b1, AMID_PC,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic addIdle(input string tag, input logic [7:0] ir, input int t,
                         input logic hd, input logic h, input logic r);
    addVec(tag, 1'b0, ir, 4'h0, h, r, t, IDLE, IDLE, 1'b0, AMID_PC,
           1'b0, 1'b0, 1'b0, hd, 1'b1);
  endtask

  task automatic addBus(input string tag, input logic [7:0] ir, input logic [3:0] st,
                        input int t, input int m, input int s, input logic [1:0] am,
                        input logic pc);
    addVec(tag, 1'b0, ir, st, 1'b0, 1'b0, t, m, s, 1'b1, am, pc, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset      = v.rst;
    ir0        = v.ir;
    alu_status = v.st;
    hlt        = v.h;
    resume     = v.r;
    expQ.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    logic [4:0] expOp;
    if (expQ.size() == 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
      return;
    end
    e = expQ.pop_front();
    expOp = e.alu ? e.ir[4:0] : 5'd0;
    check({e.tag, ".t_state"}, 32'(t_state), 32'(e.t));
    check({e.tag, ".mid_en"}, 32'(mid_en), 32'(e.en));
    check({e.tag, ".sid_en"}, 32'(sid_en), 32'(e.en));
    check({e.tag, ".pc_inr"}, 32'(pc_inr), 32'(e.pc));
    check({e.tag, ".ar_inr"}, 32'(ar_inr), 32'(e.ar));
    check({e.tag, ".alu_en"}, 32'(alu_en), 32'(e.alu));
    check({e.tag, ".alu_opcode"}, 32'(alu_opcode), 32'(expOp));
    check({e.tag, ".halted"}, 32'(halted), 32'(e.halted));
    if (e.chkId) begin
      check({e.tag, ".mid"}, 32'(mid), 32'(e.mid));
      check({e.tag, ".sid"}, 32'(sid), 32'(e.sid));
      check({e.tag, ".amid"}, 32'(amid), 32'(e.amid));
    end
  endtask

  initial begin
    reset = 1'b1; hlt = 1'b0; resume = 1'b0; ir0 = 8'h00; alu_status = 4'h0;

    addFetch("mov_ab.T0", 8'h13);
    addBus("mov_ab.T1", 8'h13, 4'h0, 1, ID_A, ID_B, AMID_PC, 1'b0);
    addFetch("mov_mema.T0", 8'h0A);
    addBus("mov_mema.T1", 8'h0A, 4'h0, 1, ID_MEM, ID_A, AMID_AR, 1'b0);
    addFetch("mvi_a.T0", 8'h42);
    addBus("mvi_a.T1", 8'h42, 4'h0, 1, ID_MEM, ID_A, AMID_PC, 1'b1);
    addFetch("alu05.T0", 8'h85);
    addVec("alu05.T1", 1'b0, 8'h85, 4'h0, 1'b0, 1'b0, 1, IDLE, IDLE, 1'b0, AMID_PC,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    addFetch("alu1a.T0", 8'hBA);
    addVec("alu1a.T1", 1'b0, 8'hBA, 4'h0, 1'b0, 1'b0, 1, IDLE, IDLE, 1'b0, AMID_PC,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    addFetch("incar.T0", 8'hC2);
    addVec("incar.T1", 1'b0, 8'hC2, 4'h0, 1'b0, 1'b0, 1, IDLE, IDLE, 1'b0, AMID_PC,
           1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    addFetch("nop.T0", 8'hC0);
    addIdle("nop.T1", 8'hC0, 1, 1'b0, 1'b0, 1'b0);
    addFetch("sysff.T0", 8'hFF);
    addIdle("sysff.T1", 8'hFF, 1, 1'b0, 1'b0, 1'b0);
    addFetch("mov_res.T0", 8'h13);
    addVec("mov_res.T1", 1'b0, 8'h13, 4'h0, 1'b0, 1'b1, 1, ID_A, ID_B, 1'b1, AMID_PC,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    addFetch("jmp.T0", 8'hC3);
    addBus("jmp.T1", 8'hC3, 4'h0, 1, ID_MEM, ID_AR0, AMID_PC, 1'b1);
    addBus("jmp.T2", 8'hC3, 4'h0, 2, ID_MEM, ID_AR1, AMID_PC, 1'b1);
    addBus("jmp.T3", 8'hC3, 4'h0, 3, ID_AR0, ID_PC0, AMID_PC, 1'b0);
    addBus("jmp.T4", 8'hC3, 4'h0, 4, ID_AR1, ID_PC1, AMID_PC, 1'b0);

    addFetch("jz0.T0", 8'hC4);
    addBus("jz0.T1", 8'hC4, 4'h0, 1, ID_MEM, ID_AR0, AMID_PC, 1'b1);
    addBus("jz0.T2", 8'hC4, 4'h0, 2, ID_MEM, ID_AR1, AMID_PC, 1'b1);
    addFetch("jzE.T0", 8'hC4);
    addBus("jzE.T1", 8'hC4, 4'hE, 1, ID_MEM, ID_AR0, AMID_PC, 1'b1);
    addBus("jzE.T2", 8'hC4, 4'hE, 2, ID_MEM, ID_AR1, AMID_PC, 1'b1);
    addFetch("jz1.T0", 8'hC4);
    addBus("jz1.T1", 8'hC4, 4'h1, 1, ID_MEM, ID_AR0, AMID_PC, 1'b1);
    addBus("jz1.T2", 8'hC4, 4'h1, 2, ID_MEM, ID_AR1, AMID_PC, 1'b1);
    addBus("jz1.T3", 8'hC4, 4'h1, 3, ID_AR0, ID_PC0, AMID_PC, 1'b0);
    addBus("jz1.T4", 8'hC4, 4'h1, 4, ID_AR1, ID_PC1, AMID_PC, 1'b0);

    addFetch("jmph.T0", 8'hC3);
    addBus("jmph.T1", 8'hC3, 4'h0, 1, ID_MEM, ID_AR0, AMID_PC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      addVec("jmph.T2frozen", 1'b0, 8'hC3, 4'h0, 1'b1, 1'b0, 2, IDLE, IDLE, 1'b0,
             AMID_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    addBus("jmph.T2", 8'hC3, 4'h0, 2, ID_MEM, ID_AR1, AMID_PC, 1'b1);
    addVec("jmph.T3rst", 1'b1, 8'hC3, 4'h0, 1'b0, 1'b0, 3, IDLE, IDLE, 1'b0, AMID_PC,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    addVec("rst.held", 1'b1, 8'h13, 4'h0, 1'b0, 1'b0, 0, IDLE, IDLE, 1'b0, AMID_PC,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    addFetch("postrst.T0", 8'h13);
    addBus("postrst.T1", 8'h13, 4'h0, 1, ID_A, ID_B, AMID_PC, 1'b0);

    addFetch("hlt.T0", 8'hC1);
    addIdle("hlt.T1", 8'hC1, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      addIdle("halted", 8'hC1, 1, 1'b1, 1'b0, 1'b0);
    end
    addIdle("halted.hltres", 8'hC1, 1, 1'b1, 1'b1, 1'b1);
    addIdle("halted.after", 8'hC1, 1, 1'b1, 1'b0, 1'b0);
    addIdle("halted.resume", 8'hC1, 1, 1'b1, 1'b0, 1'b1);
    addFetch("resumed.T0", 8'h13);
    addBus("resumed.T1", 8'h13, 4'h0, 1, ID_A, ID_B, AMID_PC, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.t_state", 32'(t_state), 32'd0);
    check("reset.mid", 32'(mid), 32'(IDLE));
    check("reset.sid", 32'(sid), 32'(IDLE));
    check("reset.mid_en", 32'(mid_en), 32'd0);
    check("reset.pc_inr", 32'(pc_inr), 32'd0);
    check("reset.amid", 32'(amid), 32'd0);
    check("reset.halted", 32'(halted), 32'd0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
